// File: rtl/aclk_alarm_bank.sv
// NUM_ALARMS-slot BCD hh:mm alarm bank: validated loads, minute-tick matching, ring/snooze/stop sequencing.
// Load/clear and state changes land on the next edge (ack/err/alarm_hit one cycle later); readback is combinational; no backpressure.
module aclk_alarm_bank #(
  parameter int NUM_ALARMS = 4,
  parameter int IDX_W      = 2,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_MIN   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_new_a,
  input  logic [IDX_W-1:0]      load_idx,
  input  logic [3:0]            new_alarm_ms_hr,
  input  logic [3:0]            new_alarm_ls_hr,
  input  logic [3:0]            new_alarm_ms_min,
  input  logic [3:0]            new_alarm_ls_min,
  input  logic                  clr_a,
  input  logic [IDX_W-1:0]      clr_idx,
  input  logic [3:0]            cur_ms_hr,
  input  logic [3:0]            cur_ls_hr,
  input  logic [3:0]            cur_ms_min,
  input  logic [3:0]            cur_ls_min,
  input  logic                  min_tick,
  input  logic                  snooze_req,
  input  logic                  stop_req,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [3:0]            rd_ms_hr,
  output logic [3:0]            rd_ls_hr,
  output logic [3:0]            rd_ms_min,
  output logic [3:0]            rd_ls_min,
  output logic [NUM_ALARMS-1:0] alarm_en,
  output logic                  load_ack,
  output logic                  load_err,
  output logic                  alarm_hit,
  output logic [IDX_W-1:0]      act_idx,
  output logic                  ringing,
  output logic                  snoozing
);

  localparam int CNT_W = 6;

  typedef enum logic [1:0] {IDLE = 2'd0, RINGING = 2'd1, SNOOZE = 2'd2} state_t;

  logic [15:0]           slot_q [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] en_q;
  state_t                state_q, state_d;
  logic [IDX_W-1:0]      act_q, act_d;
  logic [CNT_W-1:0]      ring_q, ring_d, snz_q, snz_d;
  logic                  hit_q, hit_d;

  logic                  time_ok, load_ok, match_vld, ovr;
  logic [IDX_W-1:0]      match_idx;
  logic [15:0]           new_time, cur_time, rd_time;

  assign new_time = {new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min};
  assign cur_time = {cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min};

  assign time_ok = (new_alarm_ms_hr <= 4'd2) && (new_alarm_ls_hr <= 4'd9) &&
                   !((new_alarm_ms_hr == 4'd2) && (new_alarm_ls_hr > 4'd3)) &&
                   (new_alarm_ms_min <= 4'd5) && (new_alarm_ls_min <= 4'd9);
  assign load_ok = time_ok && (32'(load_idx) < 32'(NUM_ALARMS));

  // Descending scan so the lowest matching index is the one left standing
  always_comb begin
    match_vld = 1'b0;
    match_idx = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (min_tick && en_q[i] && (slot_q[i] == cur_time)) begin
        match_vld = 1'b1;
        match_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    rd_time = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (rd_idx == IDX_W'(i)) rd_time = slot_q[i];
    end
  end

  assign {rd_ms_hr, rd_ls_hr, rd_ms_min, rd_ls_min} = rd_time;

  // Any edit to the ringing/snoozing slot cancels the alarm outright
  assign ovr = (state_q != IDLE) &&
               ((clr_a && (clr_idx == act_q)) ||
                (load_new_a && load_ok && (load_idx == act_q)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ALARMS; i++) slot_q[i] <= '0;
      en_q     <= '0;
      load_ack <= 1'b0;
      load_err <= 1'b0;
    end else begin
      load_ack <= load_new_a && load_ok;
      load_err <= load_new_a && !load_ok;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (clr_a && (clr_idx == IDX_W'(i))) en_q[i] <= 1'b0;
        if (load_new_a && load_ok && (load_idx == IDX_W'(i))) begin
          slot_q[i] <= new_time;
          en_q[i]   <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    ring_d  = ring_q;
    snz_d   = snz_q;
    hit_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (match_vld) begin
          state_d = RINGING;
          act_d   = match_idx;
          ring_d  = '0;
          hit_d   = 1'b1;
        end
      end
      RINGING: begin
        if (stop_req) begin
          state_d = IDLE;
        end else if (snooze_req) begin
          state_d = SNOOZE;
          snz_d   = CNT_W'(SNOOZE_MIN);
        end else if (min_tick) begin
          if (ring_q == CNT_W'(RING_MIN - 1)) state_d = IDLE;
          else                                ring_d  = ring_q + 1'b1;
        end
      end
      SNOOZE: begin
        if (stop_req) begin
          state_d = IDLE;
        end else if (min_tick) begin
          snz_d = snz_q - 1'b1;
          if (snz_q == CNT_W'(1)) begin
            state_d = RINGING;
            ring_d  = '0;
            hit_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (ovr) begin
      state_d = IDLE;
      hit_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      act_q   <= '0;
      ring_q  <= '0;
      snz_q   <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      ring_q  <= ring_d;
      snz_q   <= snz_d;
      hit_q   <= hit_d;
    end
  end

  assign alarm_en  = en_q;
  assign act_idx   = act_q;
  assign alarm_hit = hit_q;
  assign ringing   = (state_q == RINGING);
  assign snoozing  = (state_q == SNOOZE);

endmodule
